// File: rtl/nanci_pkg.sv
// Shared types and helpers for the Nanci mesh sorter: packet layout, snake
// ordering of PEs and the sort-key comparison.
package nanci_pkg;

    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 2;
    localparam int WIDTH          = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

    // Packet layout for the default configuration; wider builds use the same
    // field order {empty, addr, data} as a flat vector.
    typedef struct packed {
        logic                      empty;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } pkt_t;

    // Boustrophedon order; the mapping is its own inverse, so it also gives
    // the PE index sitting at a given snake position.
    function automatic int snake_pos(input int idx, input int sqrt_n);
        int row;
        int col;
        row = idx / sqrt_n;
        col = idx % sqrt_n;
        if (row % 2 == 1)
            return row * sqrt_n + (sqrt_n - 1 - col);
        return idx;
    endfunction

    // Key is {empty, s(addr)}: empty slots outrank every occupied one.
    function automatic logic key_gt(input logic a_empty, input int a_addr,
                                    input logic b_empty, input int b_addr,
                                    input int sqrt_n);
        int ka;
        int kb;
        ka = (a_empty ? sqrt_n * sqrt_n : 0) + snake_pos(a_addr, sqrt_n);
        kb = (b_empty ? sqrt_n * sqrt_n : 0) + snake_pos(b_addr, sqrt_n);
        return ka > kb;
    endfunction

endpackage

// File: rtl/nanci_pe.sv
// One mesh processing element: a packet register that reloads its initial
// packet on reset and otherwise takes a neighbour's packet when told to swap.
module nanci_pe
    import nanci_pkg::*;
#(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 2,
    parameter int IDX        = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] prev_pkt,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] next_pkt,
    input  logic                           take_prev,
    input  logic                           take_next,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] pkt
);

    localparam int PW = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [PW-1:0] INIT_PKT =
        {1'b0, ADDR_WIDTH'(N - 1 - IDX), DATA_WIDTH'(IDX)};

    if (1) begin : app_init
        logic [PW-1:0] nanci_result;
        logic [PW-1:0] nanci_result_d;

        // take_prev and take_next never fire together: they belong to pairs
        // of opposite parity.
        always_comb begin
            nanci_result_d = nanci_result;
            if (take_prev)
                nanci_result_d = prev_pkt;
            else if (take_next)
                nanci_result_d = next_pkt;
        end

        always_ff @(posedge clk) begin
            if (rst)
                nanci_result <= INIT_PKT;
            else
                nanci_result <= nanci_result_d;
        end
    end

    assign pkt = app_init.nanci_result;

endmodule

// File: rtl/nanci_mesh.sv
// Nanci mesh routing core: odd-even transposition sort of one packet per PE
// along the snake order. Optional `results` port under MESH_RESULT_PORT_EN.
module nanci_mesh
    import nanci_pkg::*;
#(
    parameter int N           = 4,
    parameter int SQRT_N      = 2,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 2,
    parameter int SORT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    output logic done
`ifdef MESH_RESULT_PORT_EN
    ,
    output logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0] results
`endif
);

    localparam int PW  = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int PCW = $clog2(SORT_CYCLES + 2);

    logic [PCW-1:0] phase_q, phase_d;
    logic           done_q, done_d;
    logic           active;

    logic [N-1:0][PW-1:0] pkt_at_pe;
    logic [N-1:0][PW-1:0] pkt_at_pos;
    logic [N-1:0]         swap;

    // Counter saturates at SORT_CYCLES, which also freezes all swaps.
    assign active = (phase_q < PCW'(SORT_CYCLES));

    always_comb begin
        phase_d = phase_q;
        if (active)
            phase_d = phase_q + 1'b1;
        done_d = (phase_d == PCW'(SORT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    for (genvar i = 0; i < N; i++) begin : G_POS
        assign pkt_at_pos[i] = pkt_at_pe[snake_pos(i, SQRT_N)];
    end

    // swap[i] exchanges snake positions i and i+1 this cycle.
    for (genvar i = 0; i < N - 1; i++) begin : G_CMP
        assign swap[i] = active && (int'(phase_q[0]) == i % 2) &&
            key_gt(pkt_at_pos[i][PW-1],   int'(pkt_at_pos[i][PW-2:DATA_WIDTH]),
                   pkt_at_pos[i+1][PW-1], int'(pkt_at_pos[i+1][PW-2:DATA_WIDTH]),
                   SQRT_N);
    end
    assign swap[N-1] = 1'b0;

    for (genvar k = 0; k < N; k++) begin : GEN
        localparam int SP = snake_pos(k, SQRT_N);
        logic [PW-1:0] prev_pkt;
        logic [PW-1:0] next_pkt;
        logic          take_prev;
        logic          take_next;

        if (SP > 0) begin : G_PREV
            assign prev_pkt  = pkt_at_pos[SP-1];
            assign take_prev = swap[SP-1];
        end else begin : G_NOPREV
            assign prev_pkt  = '0;
            assign take_prev = 1'b0;
        end

        if (SP < N - 1) begin : G_NEXT
            assign next_pkt  = pkt_at_pos[SP+1];
            assign take_next = swap[SP];
        end else begin : G_NONEXT
            assign next_pkt  = '0;
            assign take_next = 1'b0;
        end

        if (k < N) begin : GENIF
            nanci_pe #(
                .N         (N),
                .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH),
                .IDX       (k)
            ) PE (
                .clk      (clk),
                .rst      (rst),
                .prev_pkt (prev_pkt),
                .next_pkt (next_pkt),
                .take_prev(take_prev),
                .take_next(take_next),
                .pkt      (pkt_at_pe[k])
            );
        end
    end

`ifdef MESH_RESULT_PORT_EN
    assign results = pkt_at_pe;
`endif

endmodule

// File: tb/tb_nanci_mesh.sv
// Directed bench for nanci_mesh: cycle-by-cycle table for N=4 with
// SORT_CYCLES 4/2/0, an N=16 full sort and a mid-sort reset sequence.
module tb_nanci_mesh;

    logic clk;
    logic rst;
    logic done4, done16, done2, done0;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef MESH_RESULT_PORT_EN
    logic [19:0]  res4;
    logic [143:0] res16;
    logic [19:0]  res2;
    logic [19:0]  res0;
`endif

    nanci_mesh mesh (
        .clk(clk), .rst(rst), .done(done4)
`ifdef MESH_RESULT_PORT_EN
        , .results(res4)
`endif
    );

    nanci_mesh #(.N(16), .SQRT_N(4), .ADDR_WIDTH(4), .DATA_WIDTH(4), .SORT_CYCLES(16)) mesh16 (
        .clk(clk), .rst(rst), .done(done16)
`ifdef MESH_RESULT_PORT_EN
        , .results(res16)
`endif
    );

    nanci_mesh #(.SORT_CYCLES(2)) mesh2 (
        .clk(clk), .rst(rst), .done(done2)
`ifdef MESH_RESULT_PORT_EN
        , .results(res2)
`endif
    );

    nanci_mesh #(.SORT_CYCLES(0)) mesh0 (
        .clk(clk), .rst(rst), .done(done0)
`ifdef MESH_RESULT_PORT_EN
        , .results(res0)
`endif
    );

    logic [3:0][4:0]  v4, v2, v0;
    logic [15:0][8:0] v16;

    for (genvar k = 0; k < 4; k++) begin : RD4
        assign v4[k] = mesh.GEN[k].GENIF.PE.app_init.nanci_result;
        assign v2[k] = mesh2.GEN[k].GENIF.PE.app_init.nanci_result;
        assign v0[k] = mesh0.GEN[k].GENIF.PE.app_init.nanci_result;
    end
    for (genvar k = 0; k < 16; k++) begin : RD16
        assign v16[k] = mesh16.GEN[k].GENIF.PE.app_init.nanci_result;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0][4:0] pk(input logic [4:0] p0, input logic [4:0] p1,
                                            input logic [4:0] p2, input logic [4:0] p3);
        logic [3:0][4:0] r;
        r[0] = p0; r[1] = p1; r[2] = p2; r[3] = p3;
        return r;
    endfunction

    typedef struct {
        logic            d4;
        logic [3:0][4:0] p4;
        logic            d2;
        logic [3:0][4:0] p2;
        logic            d0;
    } vec_t;

    vec_t tbl [7];
    logic [3:0][4:0] init4;
    logic [3:0][4:0] sorted4;

`ifdef MESH_RESULT_PORT_EN
    logic port_chk_en = 1'b0;
    always @(negedge clk) begin
        if (port_chk_en) begin
            chk("results4", 256'(res4), 256'(v4));
            chk("results16", 256'(res16), 256'(v16));
            chk("results2", 256'(res2), 256'(v2));
            chk("results0", 256'(res0), 256'(v0));
        end
    end
`endif

    initial begin
        init4   = pk(5'h0C, 5'h09, 5'h06, 5'h03);
        sorted4 = pk(5'h03, 5'h06, 5'h09, 5'h0C);
        // index = rising edges since reset release
        tbl[0] = '{1'b0, init4,                           1'b0, init4,                           1'b0};
        tbl[1] = '{1'b0, init4,                           1'b0, init4,                           1'b1};
        tbl[2] = '{1'b0, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1};
        tbl[3] = '{1'b0, pk(5'h03, 5'h0C, 5'h09, 5'h06), 1'b1, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1};
        tbl[4] = '{1'b1, sorted4,                         1'b1, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1};
        tbl[5] = '{1'b1, sorted4,                         1'b1, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1};
        tbl[6] = '{1'b1, sorted4,                         1'b1, pk(5'h0C, 5'h03, 5'h06, 5'h09), 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
`ifdef MESH_RESULT_PORT_EN
        port_chk_en = 1'b1;
`endif
        rst = 1'b0;

        for (int c = 0; c < 7; c++) begin
            chk($sformatf("c%0d pe4", c),   256'(v4),    256'(tbl[c].p4));
            chk($sformatf("c%0d done4", c), 256'(done4), 256'(tbl[c].d4));
            chk($sformatf("c%0d pe2", c),   256'(v2),    256'(tbl[c].p2));
            chk($sformatf("c%0d done2", c), 256'(done2), 256'(tbl[c].d2));
            chk($sformatf("c%0d pe0", c),   256'(v0),    256'(init4));
            chk($sformatf("c%0d done0", c), 256'(done0), 256'(tbl[c].d0));
            @(negedge clk);
        end

        // N=16 must be fully sorted well after 16 phases
        repeat (93) @(negedge clk);
        for (int k = 0; k < 16; k++)
            chk($sformatf("pe16[%0d]", k), 256'(v16[k]), 256'({1'b0, 4'(k), 4'(15 - k)}));
        chk("done16", 256'(done16), 256'(1'b1));
        chk("final pe4", 256'(v4), 256'(sorted4));
        chk("final done4", 256'(done4), 256'(1'b1));

        // Mid-sort reset after two phases
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid pe4 before rst", 256'(v4), 256'(pk(5'h0C, 5'h03, 5'h06, 5'h09)));
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst pe4", 256'(v4), 256'(init4));
        chk("mid rst done4", 256'(done4), 256'(1'b0));
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid c%0d done4", c), 256'(done4), 256'(c == 4));
        end
        chk("mid final pe4", 256'(v4), 256'(sorted4));
        repeat (3) @(negedge clk);
        chk("mid hold pe4", 256'(v4), 256'(sorted4));
        chk("mid hold done4", 256'(done4), 256'(1'b1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
